// File: rtl/rgb_to_yuv_encoder.sv
// Streams a packed RGB frame from SRAM, converts it to Y/U/V (U/V halved horizontally) and writes
// the decoder's segment layout back. Repeating 16-cycle schedule: reads for group g+1 overlap g.
module rgb_to_yuv_encoder #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned RGB_BASE   = 146944,
  parameter int unsigned Y_BASE     = 0,
  parameter int unsigned U_BASE     = 38400,
  parameter int unsigned V_BASE     = 57600,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        start,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        busy,
  output logic        done
);

  localparam int unsigned NumGroups = IMG_WIDTH * IMG_HEIGHT / 4;
  localparam int unsigned CapFirst  = RD_LAT + 1;
  localparam int unsigned CapLast   = RD_LAT + 6;

  typedef enum logic [2:0] {StIdle, StLeadIn, StCommon, StLeadOut, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cyc_q, cyc_d;
  logic [17:0]       grp_q, grp_d;
  logic [5:0][15:0]  rbuf_q, rbuf_d;
  logic [11:0][7:0]  wbuf_q, wbuf_d;
  logic [3:0][7:0]   y_q, y_d, u_q, u_d, v_q, v_d;
  logic [17:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_n_q, we_n_d, busy_q, busy_d, done_q, done_d;

  // Compute slot: cycles 0..11 hold pixel (cyc/3), component (cyc%3)
  logic [1:0]        pix, comp;
  logic [3:0]        r_idx;
  logic [2:0]        cap_idx;
  logic [7:0]        r8, g8, b8, clipped;
  logic signed [31:0] c_r, c_g, c_b, c_off, sum, shifted;
  logic [8:0]        u_avg0, u_avg1, v_avg0, v_avg1;
  logic [17:0]       wgrp;

  always_comb begin
    pix     = 2'(cyc_q / 4'd3);
    comp    = 2'(cyc_q % 4'd3);
    r_idx   = 4'd11 - {1'b0, pix, 1'b0} - {2'b00, pix};
    r8      = wbuf_q[r_idx];
    g8      = wbuf_q[r_idx - 4'd1];
    b8      = wbuf_q[r_idx - 4'd2];
    unique case (comp)
      2'd0:    begin c_r = 32'sd16843; c_g = 32'sd33030;  c_b = 32'sd6423;  c_off = 32'sd16 <<< 16; end
      2'd1:    begin c_r = -32'sd9699; c_g = -32'sd19071; c_b = 32'sd28770; c_off = 32'sd128 <<< 16; end
      default: begin c_r = 32'sd28770; c_g = -32'sd24117; c_b = -32'sd4653; c_off = 32'sd128 <<< 16; end
    endcase
    sum = c_r * $signed({24'd0, r8}) + c_g * $signed({24'd0, g8}) + c_b * $signed({24'd0, b8})
        + c_off + 32'sd32768;
    shifted = sum >>> 16;
    if (shifted < 0)              clipped = 8'd0;
    else if (shifted > 32'sd255)  clipped = 8'd255;
    else                          clipped = shifted[7:0];
    u_avg0  = {1'b0, u_q[0]} + {1'b0, u_q[1]} + 9'd1;
    u_avg1  = {1'b0, u_q[2]} + {1'b0, u_q[3]} + 9'd1;
    v_avg0  = {1'b0, v_q[0]} + {1'b0, v_q[1]} + 9'd1;
    v_avg1  = {1'b0, v_q[2]} + {1'b0, v_q[3]} + 9'd1;
    cap_idx = 3'(cyc_q - 4'(CapFirst));
    wgrp    = grp_q - 18'd1;
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    grp_d   = grp_q;
    rbuf_d  = rbuf_q;
    wbuf_d  = wbuf_q;
    y_d     = y_q;
    u_d     = u_q;
    v_d     = v_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_n_d  = 1'b1;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A start landing on the done cycle belongs to the finished frame
        if (start && !done_q) begin
          state_d = StLeadIn;
          busy_d  = 1'b1;
          cyc_d   = 4'd0;
          grp_d   = 18'd0;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        cyc_d = cyc_q + 4'd1;
        if (cyc_q == 4'd15) grp_d = grp_q + 18'd1;
        if ((state_q == StLeadIn || state_q == StCommon) && cyc_q < 4'd6) begin
          addr_d = 18'(RGB_BASE) + grp_q * 18'd6 + {14'd0, cyc_q};
        end
        if (cyc_q >= 4'(CapFirst) && cyc_q <= 4'(CapLast)) rbuf_d[3'd5 - cap_idx] = SRAM_read_data;
        if (cyc_q == 4'd15) wbuf_d = rbuf_q;
        if (grp_q != 18'd0) begin
          if (cyc_q < 4'd12) begin
            unique case (comp)
              2'd0:    y_d[pix] = clipped;
              2'd1:    u_d[pix] = clipped;
              default: v_d[pix] = clipped;
            endcase
          end else begin
            we_n_d = 1'b0;
            unique case (cyc_q[1:0])
              2'd0: begin addr_d = 18'(Y_BASE) + (wgrp << 1);        wdata_d = {y_q[0], y_q[1]}; end
              2'd1: begin addr_d = 18'(Y_BASE) + (wgrp << 1) + 18'd1; wdata_d = {y_q[2], y_q[3]}; end
              2'd2: begin addr_d = 18'(U_BASE) + wgrp; wdata_d = {u_avg0[8:1], u_avg1[8:1]}; end
              default: begin addr_d = 18'(V_BASE) + wgrp; wdata_d = {v_avg0[8:1], v_avg1[8:1]}; end
            endcase
          end
        end
        if (state_q == StLeadIn && cyc_q == 4'(RD_LAT - 1)) state_d = StCommon;
        if (state_q == StCommon && cyc_q == 4'd5 && grp_q == 18'(NumGroups - 1)) begin
          state_d = StLeadOut;
        end
        if (state_q == StLeadOut && cyc_q == 4'd15 && grp_q == 18'(NumGroups)) state_d = StDone;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      grp_q   <= '0;
      rbuf_q  <= '0;
      wbuf_q  <= '0;
      y_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      grp_q   <= grp_d;
      rbuf_q  <= rbuf_d;
      wbuf_q  <= wbuf_d;
      y_q     <= y_d;
      u_q     <= u_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Bench for rgb_to_yuv_encoder on an 8x2 frame: table-driven uniform patterns, a random frame
// against a formula model, start-while-busy, start-at-done and mid-frame reset.
module tb_rgb_to_yuv_encoder;

  localparam int unsigned W        = 8;
  localparam int unsigned H        = 2;
  localparam int unsigned NG       = W * H / 4;
  localparam int unsigned NWORDS   = NG * 6;
  localparam int unsigned RGB_BASE = 146944;
  localparam int unsigned Y_BASE   = 0;
  localparam int unsigned U_BASE   = 38400;
  localparam int unsigned V_BASE   = 57600;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        start;
  logic [15:0] SRAM_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        busy;
  logic        done;

  always #5 Clock = ~Clock;

  rgb_to_yuv_encoder #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .RGB_BASE(RGB_BASE), .Y_BASE(Y_BASE),
    .U_BASE(U_BASE), .V_BASE(V_BASE), .RD_LAT(2)
  ) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .SRAM_read_data(SRAM_read_data),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
    .busy(busy), .done(done)
  );

  // SRAM read port: address seen in cycle t, data valid in cycle t+2
  logic [15:0] rgb_mem [NWORDS];
  logic [15:0] rd_p1;

  function automatic logic [15:0] sram_rd(input logic [17:0] a);
    int i;
    i = int'(a) - int'(RGB_BASE);
    if (i >= 0 && i < int'(NWORDS)) return rgb_mem[i];
    return 16'hDEAD;
  endfunction

  always @(posedge Clock) begin
    rd_p1          <= sram_rd(SRAM_address);
    SRAM_read_data <= rd_p1;
  end

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    string       name;
    logic [95:0] words;
    logic [15:0] y0, y1, u, v;
  } vec_t;
  vec_t vecs[5];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int a, input logic [15:0] d);
    wr_t e;
    e.addr = 18'(a);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic sb_match(input logic [17:0] a, input logic [15:0] d);
    int idx = -1;
    checks++;
    foreach (sb[i]) if (sb[i].addr == a && idx < 0) idx = i;
    if (idx < 0) begin
      failures++;
      $display("FAIL write_addr: got unexpected write 0x%0h to 0x%0h, required a pending address",
               d, a);
    end else begin
      if (sb[idx].data !== d) begin
        failures++;
        $display("FAIL write_data @0x%0h: got 0x%0h, expected 0x%0h", a, d, sb[idx].data);
      end
      sb.delete(idx);
    end
  endtask

  function automatic int conv(input int k, input int r, input int g, input int b);
    int acc;
    case (k)
      0:       acc = 16843 * r + 33030 * g + 6423 * b + (16 << 16);
      1:       acc = -9699 * r - 19071 * g + 28770 * b + (128 << 16);
      default: acc = 28770 * r - 24117 * g - 4653 * b + (128 << 16);
    endcase
    acc = (acc + 32768) >>> 16;
    if (acc < 0) acc = 0;
    if (acc > 255) acc = 255;
    return acc;
  endfunction

  task automatic model_push();
    int px[12];
    int c[3][4];
    for (int g = 0; g < int'(NG); g++) begin
      for (int k = 0; k < 6; k++) begin
        px[2*k]   = int'(rgb_mem[6*g+k][15:8]);
        px[2*k+1] = int'(rgb_mem[6*g+k][7:0]);
      end
      for (int p = 0; p < 4; p++)
        for (int k = 0; k < 3; k++) c[k][p] = conv(k, px[3*p], px[3*p+1], px[3*p+2]);
      push(Y_BASE + 2*g,     16'((c[0][0] << 8) | c[0][1]));
      push(Y_BASE + 2*g + 1, 16'((c[0][2] << 8) | c[0][3]));
      push(U_BASE + g, 16'((((c[1][0] + c[1][1] + 1) >> 1) << 8) | ((c[1][2] + c[1][3] + 1) >> 1)));
      push(V_BASE + g, 16'((((c[2][0] + c[2][1] + 1) >> 1) << 8) | ((c[2][2] + c[2][3] + 1) >> 1)));
    end
  endtask

  task automatic run_frame(input string name, input int poke_busy_at, input bit poke_at_done);
    int n_wr = 0, n_done = 0, last_wr = -100, done_at = -100, max_rd = 0;
    @(negedge Clock);
    start = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge Clock);
      if (start) start = 1'b0;
      if (c == poke_busy_at) start = 1'b1;
      if (!SRAM_we_n) begin
        n_wr++;
        last_wr = c;
        sb_match(SRAM_address, SRAM_write_data);
      end
      if (busy && SRAM_we_n && int'(SRAM_address) >= int'(RGB_BASE) && int'(SRAM_address) > max_rd)
        max_rd = int'(SRAM_address);
      if (done) begin
        n_done++;
        done_at = c;
        if (poke_at_done) start = 1'b1;
      end
      if (n_done > 0 && c >= done_at + 20) break;
    end
    start = 1'b0;
    check({name, " done_pulses"}, 32'(n_done), 32'd1);
    check({name, " write_count"}, 32'(n_wr), 32'(4 * NG));
    check({name, " pending_writes"}, 32'(sb.size()), 32'd0);
    check({name, " done_after_last_write"}, 32'(done_at), 32'(last_wr + 1));
    check({name, " last_read_addr"}, 32'(max_rd), 32'(RGB_BASE + NWORDS - 1));
    check({name, " busy_after_frame"}, 32'(busy), 32'd0);
    sb.delete();
  endtask

  logic [15:0] rand_img [NWORDS];

  initial begin
    vecs[0] = '{"black", 96'h0000_0000_0000_0000_0000_0000, 16'h1010, 16'h1010, 16'h8080, 16'h8080};
    vecs[1] = '{"white", 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080};
    vecs[2] = '{"red", 96'hFF00_00FF_0000_FF00_00FF_0000, 16'h5252, 16'h5252, 16'h5A5A, 16'hF0F0};
    vecs[3] = '{"k_rrr", 96'h0000_00FF_0000_FF00_00FF_0000, 16'h1052, 16'h5252, 16'h6D5A, 16'hB8F0};
    vecs[4] = '{"ggbb", 96'h00FF_0000_FF00_0000_FF00_00FF, 16'h9191, 16'h2929, 16'h36F0, 16'h226E};

    Reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset we_n", 32'(SRAM_we_n), 32'd1);
    check("reset addr", 32'(SRAM_address), 32'd0);
    check("reset wdata", 32'(SRAM_write_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    for (int v = 0; v < 5; v++) begin
      for (int g = 0; g < int'(NG); g++)
        for (int k = 0; k < 6; k++) rgb_mem[6*g+k] = vecs[v].words[95-16*k -: 16];
      for (int g = 0; g < int'(NG); g++) begin
        push(Y_BASE + 2*g, vecs[v].y0);
        push(Y_BASE + 2*g + 1, vecs[v].y1);
        push(U_BASE + g, vecs[v].u);
        push(V_BASE + g, vecs[v].v);
      end
      // The black frame also fires start on the done cycle, which must be ignored
      run_frame(vecs[v].name, -1, v == 0);
    end

    // Random frame, with a start pulse injected mid-frame
    for (int i = 0; i < int'(NWORDS); i++) begin
      rand_img[i] = 16'($urandom);
      rgb_mem[i]  = rand_img[i];
    end
    model_push();
    run_frame("random", 30, 1'b0);

    // Reset in the middle of a write burst
    begin
      bit seen = 1'b0;
      int stray = 0;
      @(negedge Clock);
      start = 1'b1;
      @(negedge Clock);
      start = 1'b0;
      for (int c = 0; c < 300; c++) begin
        if (!SRAM_we_n) begin
          seen = 1'b1;
          break;
        end
        @(negedge Clock);
      end
      check("write_before_reset", 32'(seen), 32'd1);
      #2 Reset = 1'b1;
      #1;
      check("midreset we_n", 32'(SRAM_we_n), 32'd1);
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset done", 32'(done), 32'd0);
      check("midreset addr", 32'(SRAM_address), 32'd0);
      @(negedge Clock);
      start = 1'b1;
      @(negedge Clock);
      start = 1'b0;
      Reset = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge Clock);
        if (!SRAM_we_n || busy || done) stray++;
      end
      check("quiet_after_reset", 32'(stray), 32'd0);
    end

    for (int i = 0; i < int'(NWORDS); i++) rgb_mem[i] = rand_img[i];
    model_push();
    run_frame("rerun", -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
